// File: rtl/quad_or.sv
// quad_or: WIDTH-lane bitwise OR with a combinational result (y) and a
// load-captured registered copy (y_q, q_valid). Synchronous active-low reset.
// Optional status outputs (any_q, all_q, ones_q) are enabled by defining
// QUAD_OR_STATUS_EN; they are registered from the same next-state value as y_q.

module quad_or_lane (
    input  logic i_a,
    input  logic i_b,
    output logic o_y
);
    // Single OR lane; an X on either input stays confined to this lane.
    assign o_y = i_a | i_b;
endmodule

module quad_or #(
    parameter int WIDTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         load,
    output logic [WIDTH-1:0]             y,
    output logic [WIDTH-1:0]             y_q,
    output logic                         q_valid
`ifdef QUAD_OR_STATUS_EN
    ,
    output logic                         any_q,
    output logic                         all_q,
    output logic [$clog2(WIDTH+1)-1:0]   ones_q
`endif
);
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] w_or;
    logic [WIDTH-1:0] r_y_q;
    logic             r_valid;

    // One independent OR cell per lane; no cross-lane logic anywhere.
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        quad_or_lane u_lane (
            .i_a (a[i]),
            .i_b (b[i]),
            .o_y (w_or[i])
        );
    end

    assign y       = w_or;
    assign y_q     = r_y_q;
    assign q_valid = r_valid;

    // Capture register: reset wins over load, otherwise hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q   <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_y_q   <= w_or;
            r_valid <= 1'b1;
        end
    end

`ifdef QUAD_OR_STATUS_EN
    logic [ONES_W-1:0] w_ones_nxt;
    logic              r_any;
    logic              r_all;
    logic [ONES_W-1:0] r_ones;

    // Population count of the value about to be captured.
    always_comb begin
        w_ones_nxt = '0;
        for (int i = 0; i < WIDTH; i++)
            w_ones_nxt = w_ones_nxt + ONES_W'(w_or[i]);
    end

    // Status registered from the same next-state as y_q so it is never a cycle behind.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_any  <= 1'b0;
            r_all  <= 1'b0;
            r_ones <= '0;
        end else if (load) begin
            r_any  <= |w_or;
            r_all  <= &w_or;
            r_ones <= w_ones_nxt;
        end
    end

    assign any_q  = r_any;
    assign all_q  = r_all;
    assign ones_q = r_ones;
`endif

endmodule

// File: tb/tb_quad_or.sv
// Testbench for quad_or: directed combinational table, directed registered
// sequence, then randomized register traffic against a behavioural model.
// Status outputs are checked when QUAD_OR_STATUS_EN is defined.

module tb_quad_or;
    localparam int WIDTH  = 4;
    localparam int ONES_W = $clog2(WIDTH + 1);

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             load;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             q_valid;
`ifdef QUAD_OR_STATUS_EN
    logic              any_q;
    logic              all_q;
    logic [ONES_W-1:0] ones_q;
`endif

    int n_chk;
    int n_err;

    // Behavioural model state
    logic [WIDTH-1:0] m_yq;
    logic             m_vld;

    quad_or #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .load    (load),
        .y       (y),
        .y_q     (y_q),
        .q_valid (q_valid)
`ifdef QUAD_OR_STATUS_EN
        ,
        .any_q   (any_q),
        .all_q   (all_q),
        .ones_q  (ones_q)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Lane-by-lane reference: a lane is 1 if either operand lane is 1.
    function automatic logic [WIDTH-1:0] ref_or(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] z);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) r[i] = (x[i] == 1'b1 || z[i] == 1'b1);
        return r;
    endfunction

    task automatic comb_case(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb, input logic [WIDTH-1:0] exp);
        a = aa;
        b = bb;
        #1;
        chk("y_comb", 32'(y), 32'(exp));
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_yq"}, 32'(y_q), 32'(m_yq));
        chk({tag, "_vld"}, 32'(q_valid), 32'(m_vld));
        chk({tag, "_y"}, 32'(y), 32'(ref_or(a, b)));
`ifdef QUAD_OR_STATUS_EN
        chk({tag, "_any"}, 32'(any_q), 32'(m_yq != '0));
        chk({tag, "_all"}, 32'(all_q), 32'(m_yq == '1));
        chk({tag, "_ones"}, 32'(ones_q), 32'($countones(m_yq)));
`endif
    endtask

    // Drive one cycle (inputs set away from the edge), update the model at the edge,
    // then check at the following falling edge.
    task automatic step(input logic rr, input logic ld, input logic [WIDTH-1:0] aa,
                        input logic [WIDTH-1:0] bb, input string tag);
        rst_n = rr;
        load  = ld;
        a     = aa;
        b     = bb;
        @(posedge clk);
        if (!rr) begin
            m_yq  = '0;
            m_vld = 1'b0;
        end else if (ld) begin
            m_yq  = ref_or(aa, bb);
            m_vld = 1'b1;
        end
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        m_yq  = '0;
        m_vld = 1'b0;
        rst_n = 1'b0;
        load  = 1'b0;
        a     = '0;
        b     = '0;

        // Combinational path, no clock edge needed (reset asserted throughout).
        comb_case(4'b0000, 4'b0000, 4'h0);
        comb_case(4'b1111, 4'b1111, 4'hF);
        comb_case(4'b0001, 4'b0000, 4'h1);
        comb_case(4'b0000, 4'b0001, 4'h1);
        comb_case(4'b0001, 4'b0001, 4'h1);
        comb_case(4'b1111, 4'b0000, 4'hF);
        comb_case(4'b0000, 4'b0101, 4'h5);
        comb_case(4'b1100, 4'b1010, 4'hE);
        for (int i = 0; i < 16; i++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = WIDTH'($urandom);
            rb = WIDTH'($urandom);
            comb_case(ra, rb, ref_or(ra, rb));
        end

        // Reset for two edges, with load high to show it is ignored.
        step(1'b0, 1'b1, 4'b1111, 4'b0000, "rst1");
        step(1'b0, 1'b0, 4'b0000, 4'b0000, "rst2");
        // Capture E, then hold while y tracks new inputs.
        step(1'b1, 1'b1, 4'b1100, 4'b1010, "load_e");
        step(1'b1, 1'b0, 4'b0011, 4'b0001, "hold1");
        step(1'b1, 1'b0, 4'b0000, 4'b0000, "hold2");
        // Reset coinciding with load: load discarded.
        step(1'b0, 1'b1, 4'b1111, 4'b1111, "rst_prio");
        // Back-to-back loads and status patterns.
        step(1'b1, 1'b1, 4'b0000, 4'b0101, "ld_5");
        step(1'b1, 1'b1, 4'b1111, 4'b0000, "ld_f");
        step(1'b1, 1'b1, 4'b0000, 4'b0000, "ld_0");

        // Randomized traffic.
        for (int i = 0; i < 200; i++) begin
            logic rr, ld;
            rr = ($urandom_range(0, 15) != 0);
            ld = $urandom_range(0, 1) == 1;
            step(rr, ld, WIDTH'($urandom), WIDTH'($urandom), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/quad_or.md
Name: quad_or

Overview:
- Four-lane, bitwise 2-input OR block, equivalent to a 74xx32 quad OR gate, used as a common logic primitive in the 8-bit CPU datapath.
- Provides a combinational result `y = a | b` for same-cycle use.
- Also provides a registered copy `y_q`, captured on `load`, for pipelined consumers.
- One clock domain; synchronous active-low reset.

Parameters:
- WIDTH, 4, number of OR lanes. Each lane is independent. All vector ports scale with WIDTH. Legal range is 1..16.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- load  input  1  when high at a rising edge, capture `a | b` into `y_q`.
- y  output  WIDTH  combinational result `a | b`.
- y_q  output  WIDTH  registered result.
- q_valid  output  1  high once `y_q` holds a captured value since reset.

Behaviour:
- Clocking and reset: one clock (`clk`); reset is synchronous and active-low (`rst_n`).
- Combinational path:
  - `y[i] = a[i] | b[i]` for every lane i.
  - Zero cycle latency; purely combinational.
  - No dependence on clk, rst_n or load; `y` is valid even while reset is asserted.
  - No X-propagation masking: an X on an input lane propagates only within that lane.
- Registered path, evaluated at each rising clk edge:
  - rst_n = 0: `y_q` <= 0 and `q_valid` <= 0. Reset has priority over load.
  - rst_n = 1 and load = 1: `y_q` <= `a | b`, using the inputs sampled at that edge; `q_valid` <= 1.
  - rst_n = 1 and load = 0: `y_q` and `q_valid` hold.
- Latency: `y_q` reflects the inputs one clock after the load edge.
- `q_valid` stays 1 until the next reset; it is a sticky flag, not a per-sample strobe.
- Reset mid-operation: a load coinciding with rst_n = 0 is discarded, and `y_q` reads 0 on the next cycle.
- Back-to-back loads: each edge overwrites `y_q`. There is no queueing.
- Width rules:
  - No carries and no cross-lane interaction.
  - Result width equals WIDTH; no truncation or extension.
- Identities:
  - a = 0 gives y = b.
  - a = all-ones gives y = all-ones.
  - a = b gives y = a.

Optional Feature:
- Macro: QUAD_OR_STATUS_EN.
- When defined, three extra outputs are added, all derived from `y_q` and all cleared by reset:
  - any_q (1 bit): OR-reduction of `y_q`.
  - all_q (1 bit): AND-reduction of `y_q`.
  - ones_q ($clog2(WIDTH+1) bits): number of set bits in `y_q`.
- The status outputs update in the same cycle as `y_q`, i.e. they are computed from the next-state value and are never one cycle behind `y_q`.
- When not defined: these ports do not exist, and the rest of the block is identical.

Test Plan:
- All-zeros and all-ones: a=0000, b=0000 -> y=0; a=1111, b=1111 -> y=F; check `y` 1 time unit after the input change, with no clock needed.
- Single-lane isolation: (a=0001, b=0000), (a=0000, b=0001) and (a=0001, b=0001) -> y=1 in each case; all other lanes stay 0.
- Mixed patterns:
  - a=1111, b=0000 -> y=F.
  - a=0000, b=0101 -> y=5.
  - a=1100, b=1010 -> y=E.
- Registered path:
  - rst_n=0 for 2 edges -> y_q=0, q_valid=0.
  - Release reset; a=1100, b=1010, load=1 for one edge -> y_q=E, q_valid=1.
  - Then change a/b with load=0 -> y_q holds E while `y` tracks the new inputs.
- Reset priority: with y_q=E, assert rst_n=0 and load=1 together at one edge -> y_q=0, q_valid=0.
- With QUAD_OR_STATUS_EN defined:
  - Load a=0000, b=0101 -> any_q=1, all_q=0, ones_q=2.
  - Load a=1111, b=0000 -> all_q=1, ones_q=4.
  - Load a=0000, b=0000 -> any_q=0, ones_q=0.
